// File: rtl/axil_pkg.sv
// Shared definitions for the AXI4-Lite master: FSM state encoding and default widths.
package axil_pkg;

  localparam int unsigned AXIL_ADDR_W         = 32;
  localparam int unsigned AXIL_DATA_W         = 32;
  localparam int unsigned AXIL_TIMEOUT_CYCLES = 256;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_WRESP,
    ST_RADDR,
    ST_RDATA
  } axil_state_e;

endpackage

// File: rtl/axil_watchdog.sv
// Per-phase watchdog for axil_master: counts cycles spent in the current busy state.
// Only built when AXIL_MASTER_TIMEOUT_EN is defined.
`ifdef AXIL_MASTER_TIMEOUT_EN
module axil_watchdog #(
  parameter int unsigned LIMIT = 256
) (
  input  logic clock_i,
  input  logic reset_ni,
  input  logic active_i,
  input  logic enter_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (enter_i) begin
      cnt_d = '0;
    end else if (active_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expiry is flagged in the cycle the counter would reach LIMIT, so a phase lasts LIMIT cycles.
  assign expired_o = active_i && (cnt_q == CNT_W'(LIMIT - 1));

endmodule
`endif

// File: rtl/axil_master.sv
// Single-outstanding AXI4-Lite master bridging a simple request/response port.
// Optional watchdog abort enabled by defining AXIL_MASTER_TIMEOUT_EN.
module axil_master
  import axil_pkg::*;
#(
  parameter int unsigned ADDR_W         = AXIL_ADDR_W,
  parameter int unsigned DATA_W         = AXIL_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = AXIL_TIMEOUT_CYCLES
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                AWVALID,
  input  logic                AWREADY,
  output logic [ADDR_W-1:0]   AWADDR,
  output logic                WVALID,
  input  logic                WREADY,
  output logic [DATA_W-1:0]   WDATA,
  output logic [DATA_W/8-1:0] WSTRB,
  input  logic                BVALID,
  output logic                BREADY,
  output logic                ARVALID,
  input  logic                ARREADY,
  output logic [ADDR_W-1:0]   ARADDR,
  input  logic                RVALID,
  output logic                RREADY,
  input  logic [DATA_W-1:0]   RDATA
);

  localparam int unsigned STRB_W = DATA_W / 8;

  axil_state_e state_q, state_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              run_q;

  logic accept, aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic timeout, timeout_fire;

  assign accept = req_valid & req_ready;
  assign aw_hs  = AWVALID & AWREADY;
  assign w_hs   = WVALID & WREADY;
  assign b_hs   = BVALID & BREADY;
  assign ar_hs  = ARVALID & ARREADY;
  assign r_hs   = RVALID & RREADY;

  // A finishing B/R handshake takes priority over an expiry in the same cycle.
  assign timeout_fire = timeout & ~b_hs & ~r_hs;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = req_write ? ST_WRITE : ST_RADDR;
        end
      end
      ST_WRITE: begin
        if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) begin
          state_d = ST_WRESP;
        end
      end
      ST_WRESP: begin
        if (b_hs) begin
          state_d = ST_IDLE;
        end
      end
      ST_RADDR: begin
        if (ar_hs) begin
          state_d = ST_RDATA;
        end
      end
      ST_RDATA: begin
        if (r_hs) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (timeout_fire) begin
      state_d = ST_IDLE;
    end
  end

  // VALID/READY come straight from state so reset and abort drop them without extra flops.
  always_comb begin
    req_ready = run_q & (state_q == ST_IDLE) & ~rsp_valid_q;
    AWVALID   = (state_q == ST_WRITE) & ~aw_done_q;
    WVALID    = (state_q == ST_WRITE) & ~w_done_q;
    BREADY    = (state_q == ST_WRESP);
    ARVALID   = (state_q == ST_RADDR);
    RREADY    = (state_q == ST_RDATA);
    AWADDR    = addr_q;
    ARADDR    = addr_q;
    WDATA     = wdata_q;
    WSTRB     = wstrb_q;
    rsp_valid = rsp_valid_q;
    rsp_rdata = rdata_q;
  end

  always_comb begin
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rdata_d     = rdata_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    rsp_valid_d = b_hs | r_hs | timeout_fire;
    if (accept) begin
      addr_d    = req_addr;
      wdata_d   = req_wdata;
      wstrb_d   = req_wstrb;
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
    end else begin
      if (aw_hs) begin
        aw_done_d = 1'b1;
      end
      if (w_hs) begin
        w_done_d = 1'b1;
      end
    end
    if (r_hs) begin
      rdata_d = RDATA;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rdata_q     <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      run_q       <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rdata_q     <= rdata_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      rsp_valid_q <= rsp_valid_d;
      run_q       <= 1'b1;
    end
  end

`ifdef AXIL_MASTER_TIMEOUT_EN
  logic rsp_err_q;

  axil_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock_i  (clock),
    .reset_ni (reset),
    .active_i (state_q != ST_IDLE),
    .enter_i  ((state_d != state_q) && (state_d != ST_IDLE)),
    .expired_o(timeout)
  );

  // Aborting drops VALID mid-handshake, which AXI forbids; accepted to free a hung bus.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rsp_err_q <= 1'b0;
    end else begin
      rsp_err_q <= timeout_fire;
    end
  end

  assign rsp_err = rsp_err_q;
`else
  assign timeout = 1'b0;
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_axil_master.sv
// Scoreboard bench for axil_master: a reactive AXI-Lite slave plus a response monitor.
// The timeout scenario runs only when AXIL_MASTER_TIMEOUT_EN is defined.
module tb_axil_master;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;
  localparam int TO     = 16;

  logic              clock;
  logic              reset;
  logic              req_valid, req_ready, req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [STRB_W-1:0] req_wstrb;
  logic              rsp_valid, rsp_err;
  logic [DATA_W-1:0] rsp_rdata;
  logic              AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic              ARVALID, ARREADY, RVALID, RREADY;
  logic [ADDR_W-1:0] AWADDR, ARADDR;
  logic [DATA_W-1:0] WDATA, RDATA;
  logic [STRB_W-1:0] WSTRB;

  axil_master #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic              err;
    logic              chkData;
    logic [DATA_W-1:0] rdata;
  } exp_t;

  exp_t scb[$];

  int checkCount = 0;
  int passCount  = 0;

  int awDelay = 0, wDelay = 0, bDelay = 0, arDelay = 0, rDelay = 0;
  int awWait = 0, wWait = 0, bWait = 0, arWait = 0, rWait = 0;
  int awHigh = 0, wHigh = 0, arHigh = 0;
  int awHsCyc = 0, wHsCyc = 0;
  int acceptCyc = 0, lastRspCyc = 0;
  logic awDone = 1'b0, wDone = 1'b0;
  logic [ADDR_W-1:0] curAddr = '0;
  logic [DATA_W-1:0] curData = '0;
  logic [STRB_W-1:0] curStrb = '0;
  logic [DATA_W-1:0] lastRead = '0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rdataFor(input logic [ADDR_W-1:0] a);
    if (a == 32'h0000_2004) return 32'h1234_5678;
    return (a ^ 32'hC0DE_0000) + 32'h11;
  endfunction

  // Reactive slave: readiness and response timing are set by the *Delay knobs.
  initial begin
    AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0;
    ARREADY = 1'b0; RVALID = 1'b0; RDATA = '0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; ARREADY = 1'b0; RVALID = 1'b0;
        awWait = 0; wWait = 0; bWait = 0; arWait = 0; rWait = 0;
      end else begin
        if (AWVALID) begin
          checkOutput("AWADDR held", AWADDR, curAddr);
          AWREADY = (awWait >= awDelay);
          awWait++; awHigh++;
          if (AWREADY) begin awDone = 1'b1; awHsCyc = cyc; end
        end else begin
          AWREADY = 1'b0; awWait = 0;
        end
        if (WVALID) begin
          checkOutput("W payload held", {WSTRB, WDATA}, {curStrb, curData});
          WREADY = (wWait >= wDelay);
          wWait++; wHigh++;
          if (WREADY) begin wDone = 1'b1; wHsCyc = cyc; end
        end else begin
          WREADY = 1'b0; wWait = 0;
        end
        if (BREADY) begin
          checkOutput("BREADY after AW and W", {awDone, wDone}, 2'b11);
          BVALID = (bWait >= bDelay);
          bWait++;
        end else begin
          BVALID = 1'b0; bWait = 0;
        end
        if (ARVALID) begin
          checkOutput("ARADDR held", ARADDR, curAddr);
          ARREADY = (arWait >= arDelay);
          arWait++; arHigh++;
        end else begin
          ARREADY = 1'b0; arWait = 0;
        end
        if (RREADY) begin
          RVALID = (rWait >= rDelay);
          RDATA  = rdataFor(curAddr);
          rWait++;
        end else begin
          RVALID = 1'b0; rWait = 0;
        end
      end
    end
  end

  // Response monitor: pops the scoreboard on every rsp_valid pulse.
  initial begin
    exp_t e;
    logic prevRsp;
    prevRsp = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        prevRsp = 1'b0;
      end else begin
        if (rsp_valid) begin
          lastRspCyc = cyc;
          checkOutput("rsp_valid single pulse", prevRsp, 0);
          checkOutput("req_ready low with rsp_valid", req_ready, 0);
          checkOutput("response expected", scb.size() > 0, 1);
          if (scb.size() > 0) begin
            e = scb.pop_front();
            checkOutput("rsp_err", rsp_err, e.err);
            if (e.chkData) checkOutput("rsp_rdata", rsp_rdata, e.rdata);
          end
        end
        prevRsp = rsp_valid;
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic applyStimulus(input logic wr, input logic [ADDR_W-1:0] a,
                               input logic [DATA_W-1:0] d, input logic [STRB_W-1:0] s,
                               input logic hold, input logic expTo);
    exp_t e;
    int n;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; req_wstrb = s;
    e.err     = expTo;
    e.chkData = !wr;
    e.rdata   = expTo ? lastRead : rdataFor(a);
    if (!wr && !expTo) lastRead = rdataFor(a);
    scb.push_back(e);
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    checkOutput("request accepted", req_ready, 1);
    acceptCyc = cyc;
    curAddr = a; curData = d; curStrb = s;
    awDone = 1'b0; wDone = 1'b0; awHigh = 0; wHigh = 0; arHigh = 0;
    @(negedge clock);
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (scb.size() > 0 && n < 300) begin
      @(negedge clock);
      n++;
    end
    checkOutput("response arrived", scb.size(), 0);
    @(negedge clock);
    checkOutput("idle after response", req_ready, 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global time limit: got running, expected finished");
    $display("%0d/%0d checks passed", passCount, checkCount);
    $fatal(1, "[TB] simulation hung");
  end

  initial begin
    int n;
    reset = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    repeat (3) @(negedge clock);
    checkOutput("reset handshake outputs",
                {AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, rsp_err, req_ready}, 0);
    checkOutput("reset AWADDR/ARADDR", {AWADDR, ARADDR}, 0);
    checkOutput("reset W payload", {WSTRB, WDATA}, 0);
    checkOutput("reset rsp_rdata", rsp_rdata, 0);
    reset = 1'b1;
    #1 checkOutput("req_ready before first edge", req_ready, 0);
    @(negedge clock);
    checkOutput("req_ready after first edge", req_ready, 1);

    // Single-cycle write, all slave channels immediately ready.
    applyStimulus(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0);
    waitIdle();
    checkOutput("T1 AWVALID cycles", awHigh, 1);
    checkOutput("T1 WVALID cycles", wHigh, 1);
    checkOutput("T1 accept to rsp", lastRspCyc - acceptCyc, 3);

    // W completes three cycles ahead of AW.
    awDelay = 3;
    applyStimulus(1'b1, 32'h0000_3008, 32'hCAFE_F00D, 4'h5, 1'b0, 1'b0);
    waitIdle();
    checkOutput("T2 AW after W gap", awHsCyc - wHsCyc, 3);
    checkOutput("T2 WVALID cycles", wHigh, 1);
    checkOutput("T2 AWVALID cycles", awHigh, 4);
    awDelay = 0;

    // Read with ARREADY two cycles late.
    arDelay = 2;
    applyStimulus(1'b0, 32'h0000_2004, '0, '0, 1'b0, 1'b0);
    waitIdle();
    checkOutput("T3 ARVALID cycles", arHigh, 3);
    checkOutput("T3 rsp_rdata held", rsp_rdata, 32'h1234_5678);
    arDelay = 0;

    // Read with a late RVALID, then a write whose rdata must stay untouched.
    rDelay = 1;
    applyStimulus(1'b0, 32'h0000_0040, '0, '0, 1'b0, 1'b0);
    waitIdle();
    rDelay = 0; bDelay = 2; wDelay = 1;
    applyStimulus(1'b1, 32'h0000_0050, 32'h0102_0304, 4'h9, 1'b0, 1'b0);
    waitIdle();
    checkOutput("rsp_rdata kept across write", rsp_rdata, lastRead);
    bDelay = 0; wDelay = 0;

    // Back-to-back read then write with req_valid held.
    applyStimulus(1'b0, 32'h0000_0080, '0, '0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h0000_0084, 32'h5555_AAAA, 4'h3, 1'b0, 1'b0);
    checkOutput("b2b accept after rsp", acceptCyc - lastRspCyc, 1);
    waitIdle();

`ifdef AXIL_MASTER_TIMEOUT_EN
    arDelay = 10000;
    applyStimulus(1'b0, 32'h0000_9000, '0, '0, 1'b0, 1'b1);
    waitIdle();
    checkOutput("timeout ARVALID cycles", arHigh, TO);
    arDelay = 0;
`endif

    // Reset while waiting in RDATA abandons the read.
    rDelay = 10000;
    applyStimulus(1'b0, 32'h0000_2004, '0, '0, 1'b0, 1'b0);
    n = 0;
    while (!RREADY && n < 50) begin
      @(negedge clock);
      n++;
    end
    checkOutput("reached RDATA", RREADY, 1);
    #2 reset = 1'b0;
    scb.delete();
    lastRead = '0;
    #1;
    checkOutput("async reset outputs",
                {AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, rsp_err, req_ready}, 0);
    checkOutput("async reset rsp_rdata", rsp_rdata, 0);
    checkOutput("async reset ARADDR", ARADDR, 0);
    repeat (2) @(negedge clock);
    rDelay = 0;
    reset = 1'b1;
    @(negedge clock);
    checkOutput("req_ready after release", req_ready, 1);
    repeat (2) @(negedge clock);

    applyStimulus(1'b0, 32'h0000_2004, '0, '0, 1'b0, 1'b0);
    waitIdle();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/axil_master.md
AXIL_MASTER -- requirements
Module: axil_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: width of the AXI and request address.
REQ-002 SHALL have parameter DATA_W, default 32, legal values 32 and 64: data width; WSTRB width is DATA_W/8.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 256: watchdog limit in cycles, used only when the feature in REQ-027 is enabled.
REQ-004 SHALL have port clock, input, 1 bit: the single clock; all state is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have request ports req_valid (in, 1), req_ready (out, 1), req_write (in, 1), req_addr (in, ADDR_W), req_wdata (in, DATA_W) and req_wstrb (in, DATA_W/8).
REQ-007 SHALL have response ports rsp_valid (out, 1), rsp_rdata (out, DATA_W) and rsp_err (out, 1).
REQ-008 SHALL have the AXI4-Lite master ports AWVALID/AWREADY/AWADDR, WVALID/WREADY/WDATA/WSTRB, BVALID/BREADY, ARVALID/ARREADY/ARADDR and RVALID/RREADY/RDATA, with widths per REQ-001/002.

Function
REQ-009 SHALL implement the FSM states IDLE, WRITE, WRESP, RADDR and RDATA, with one transaction in flight at most.
REQ-010 SHALL drive req_ready=1 only in IDLE; a request is accepted when req_valid and req_ready are both high.
REQ-011 SHALL register the address, wdata and wstrb on acceptance and hold the AXI payload stable until the matching handshake.
REQ-012 On accepting a write, SHALL enter WRITE and assert AWVALID and WVALID from the next cycle (1-cycle latency).
REQ-013 In WRITE, SHALL deassert AWVALID and WVALID independently, each on its own handshake; AW and W may complete in either order or in the same cycle.
REQ-014 SHALL enter WRESP when both AW and W have completed, and SHALL assert BREADY only in WRESP.
REQ-015 On BVALID&BREADY, SHALL pulse rsp_valid for exactly 1 cycle next cycle with rsp_err=0, then return to IDLE.
REQ-016 On accepting a read, SHALL enter RADDR and assert ARVALID from the next cycle until ARREADY.
REQ-017 SHALL enter RDATA after the AR handshake and assert RREADY only in RDATA.
REQ-018 On RVALID&RREADY, SHALL register RDATA into rsp_rdata, pulse rsp_valid for 1 cycle, then return to IDLE.
REQ-019 rsp_rdata SHALL hold its last value until the next read completes; for writes its value is don't-care.
REQ-020 rsp_valid SHALL have no backpressure, and the consumer SHALL always accept it.
REQ-021 A new request SHALL NOT be accepted in the cycle rsp_valid is high; req_ready rises the cycle after.

Reset
REQ-022 While reset=0, SHALL force state IDLE and drive all VALID/READY outputs, rsp_valid and rsp_err to 0.
REQ-023 After reset, AWADDR, ARADDR, WDATA, WSTRB and rsp_rdata SHALL be all-zero.
REQ-024 Reset asserted mid-transaction SHALL abandon it immediately, with no response issued.
REQ-025 req_ready SHALL go to 1 on the first clock edge after reset deasserts.

Configuration
REQ-026 Without AXIL_MASTER_TIMEOUT_EN, rsp_err SHALL be tied to 0 and no watchdog logic SHALL exist.
REQ-027 With AXIL_MASTER_TIMEOUT_EN, a counter SHALL clear on entering any non-IDLE state and increment each cycle outside IDLE.
REQ-028 When the counter reaches TIMEOUT_CYCLES, SHALL deassert all AXI VALID/READY, pulse rsp_valid with rsp_err=1 and return to IDLE; this deliberate AXI protocol violation is documented.
REQ-029 If a completing handshake and the timeout occur in the same cycle, the handshake SHALL win with rsp_err=0.

Structure
REQ-030 Package axil_pkg SHALL hold the FSM state enum and default width constants.
REQ-031 The watchdog SHALL be sub-module axil_watchdog (counter plus expiry flag), instantiated only under the macro.

Verification
REQ-032 Write 0x1000/0xDEADBEEF/0xF with AWREADY=WREADY=1 and BVALID one cycle later -> AW/W valid for 1 cycle, rsp_valid 1 cycle later, rsp_err=0.
REQ-033 Write with WREADY 3 cycles before AWREADY -> WVALID drops first, AWADDR is held, BREADY rises only after AW completes.
REQ-034 Read 0x2004 with ARREADY delayed 2 cycles and RDATA=0x12345678 -> rsp_rdata=0x12345678 and one rsp_valid pulse.
REQ-035 Reset pulled low while in RDATA -> all outputs return to 0 asynchronously, no rsp_valid, req_ready=1 after release.
REQ-036 With the macro and TIMEOUT_CYCLES=16, ARREADY never rises -> ARVALID drops after 16 cycles, rsp_err=1 for one cycle, back to IDLE.
REQ-037 Back-to-back read then write with req_valid held high -> the second request is accepted the cycle after rsp_valid.
